// File: rtl/jk_pkg.sv
// Shared opcodes and FSM encoding for the JK bank sequencer.
// Reserved opcode 7 has no name here; the controller decodes it as HOLD.
package jk_pkg;

    localparam logic [2:0] OP_HOLD    = 3'd0;
    localparam logic [2:0] OP_CLEAR   = 3'd1;
    localparam logic [2:0] OP_PRESET  = 3'd2;
    localparam logic [2:0] OP_LOAD    = 3'd3;
    localparam logic [2:0] OP_CNT_UP  = 3'd4;
    localparam logic [2:0] OP_CNT_DN  = 3'd5;
    localparam logic [2:0] OP_TOGGLE  = 3'd6;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EXEC = 1'b1
    } state_t;

    function automatic logic is_count(input logic [2:0] op);
        return (op == OP_CNT_UP) || (op == OP_CNT_DN);
    endfunction

endpackage

// File: rtl/jk_bank_ctrl_if.sv
// Command channel into the JK bank controller: valid/ready plus opcode, data and step count.
// A transfer happens only on a clock edge where cmd_valid and cmd_ready are both high.
interface jk_bank_ctrl_if #(
    parameter int WIDTH  = 4,
    parameter int STEP_W = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_op;
    logic [WIDTH-1:0]  cmd_data;
    logic [STEP_W-1:0] cmd_steps;

    modport master (
        output cmd_valid, cmd_op, cmd_data, cmd_steps,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, cmd_steps,
        output cmd_ready
    );
endinterface

// File: rtl/jk_ff.sv
// Single rising-edge JK flip-flop with asynchronous active-low reset to 0.
// Truth table: 00 hold, 01 reset, 10 set, 11 toggle.
module jk_ff (
    input  logic clk,
    input  logic rst_n,
    input  logic j_i,
    input  logic k_i,
    output logic q_o
);
    logic q_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= 1'b0;
        end else begin
            case ({j_i, k_i})
                2'b01:   q_q <= 1'b0;
                2'b10:   q_q <= 1'b1;
                2'b11:   q_q <= ~q_q;
                default: q_q <= q_q;
            endcase
        end
    end

    assign q_o = q_q;
endmodule

// File: rtl/jk_bank_ctrl.sv
// Sequences a bank of JK flip-flops from one-at-a-time commands; single-step ops take one
// EXEC cycle, counts take max(steps,1) cycles; done pulses the cycle after EXEC ends.
module jk_bank_ctrl
    import jk_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int STEP_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    jk_bank_ctrl_if.slave    cmd,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic [WIDTH-1:0] jk_j,
    output logic [WIDTH-1:0] jk_k,
    output logic             busy,
    output logic             done
);
    localparam logic [STEP_W-1:0] STEP_ONE = STEP_W'(1);

    state_t            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic [STEP_W-1:0] rem_q, rem_d;
    logic              done_q, done_d;
    logic [WIDTH-1:0]  up_t, dn_t;

    // Ripple-carry toggle enables: a bit flips when every lower bit is 1 (up) or 0 (down).
    always_comb begin
        up_t    = '0;
        dn_t    = '0;
        up_t[0] = 1'b1;
        dn_t[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            up_t[i] = up_t[i-1] & q[i-1];
            dn_t[i] = dn_t[i-1] & ~q[i-1];
        end
    end

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        data_d        = data_q;
        rem_d         = rem_q;
        done_d        = 1'b0;
        jk_j          = '0;
        jk_k          = '0;
        cmd.cmd_ready = 1'b0;
        busy          = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cmd.cmd_ready = 1'b1;
                if (cmd.cmd_valid) begin
                    op_d    = cmd.cmd_op;
                    data_d  = cmd.cmd_data;
                    rem_d   = cmd.cmd_steps;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                busy = 1'b1;
                case (op_q)
                    OP_CLEAR:  jk_k = '1;
                    OP_PRESET: jk_j = '1;
                    OP_LOAD: begin
                        jk_j = data_q;
                        jk_k = ~data_q;
                    end
                    OP_TOGGLE: begin
                        jk_j = data_q;
                        jk_k = data_q;
                    end
                    OP_CNT_UP: if (rem_q != '0) begin
                        jk_j = up_t;
                        jk_k = up_t;
                    end
                    OP_CNT_DN: if (rem_q != '0) begin
                        jk_j = dn_t;
                        jk_k = dn_t;
                    end
                    default: ;
                endcase
                if (rem_q != '0) begin
                    rem_d = rem_q - STEP_ONE;
                end
                // A zero-step count still spends one EXEC cycle so it reports done.
                if (!is_count(op_q) || (rem_q <= STEP_ONE)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            data_q  <= '0;
            rem_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            data_q  <= data_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_ff
        jk_ff u_ff (
            .clk   (clk),
            .rst_n (rst_n),
            .j_i   (jk_j[g]),
            .k_i   (jk_k[g]),
            .q_o   (q[g])
        );
    end

    assign qn   = ~q;
    assign done = done_q;
endmodule
